spy_cmd_decoder: RTL and testbench

Serial spy-port command decoder. Sits directly downstream of the RS-232 byte receiver and upstream of the CPU spy bus.
- Turns received command bytes into spy-bus read and write cycles (dbread, dbwrite, eadr, spy_out).
- Returns read data to the UART transmitter as nibble-encoded bytes over a tx_req/tx_ack handshake.

---
 rtl/spy_cmd_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_spy_cmd_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spy_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : spy_cmd_decoder
//  Description : Serial spy-port command decoder. It turns command bytes from
//                the UART receiver into spy-bus read/write cycles and returns
//                read data to the UART transmitter as four nibble-encoded
//                bytes (0x30|d[3:0], 0x40|d[7:4], 0x50|d[11:8], 0x60|d[15:12]).
//
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                rx_data/rx_valid  - command byte + one-cycle strobe
//                tx_data/tx_req    - byte offered to the transmitter
//                tx_ack            - transmitter accepts when tx_req && tx_ack
//                spy_in/spy_out    - spy bus read data / write data register
//                eadr              - spy register address {opcode[0], arg}
//                dbread/dbwrite    - spy read / write strobes
//                rx_overrun        - sticky: byte arrived outside IDLE
//
//  Optional    : SPY_WRITE_ECHO_EN - when defined, each write is followed by
//                an ECHO state that sends the original command byte once.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module spy_cmd_decoder #(
    parameter int unsigned READ_CYCLES  = 2,
    parameter int unsigned WRITE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_req,
    input  logic        tx_ack,
    input  logic [15:0] spy_in,
    output logic [15:0] spy_out,
    output logic [4:0]  eadr,
    output logic        dbread,
    output logic        dbwrite,
    output logic        rx_overrun
);

    localparam int unsigned     c_CW      = 8;
    localparam logic [c_CW-1:0] c_RD_LAST = c_CW'(READ_CYCLES - 1);
    localparam logic [c_CW-1:0] c_WR_LAST = c_CW'(WRITE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_TX   = 3'd2,
`ifdef SPY_WRITE_ECHO_EN
        S_ECHO = 3'd4,
`endif
        S_WR   = 3'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_data;
    logic [15:0]     r_rdat;
    logic [4:0]      r_eadr;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_idx;
    logic            r_ovr;
`ifdef SPY_WRITE_ECHO_EN
    logic [7:0]      r_cmd;
`endif

    logic [3:0] w_opc;
    logic [3:0] w_arg;
    logic       w_accept;
    logic       w_is_rd;
    logic       w_is_wr;
    logic       w_rd_last;
    logic       w_wr_last;
    logic [7:0] w_tx_data;

    assign w_opc     = rx_data[7:4];
    assign w_arg     = rx_data[3:0];
    // Bytes are only taken in IDLE; anything else counts as an overrun.
    assign w_accept  = rx_valid && (r_state == S_IDLE);
    assign w_is_rd   = (w_opc == 4'h8) || (w_opc == 4'h9);
    assign w_is_wr   = (w_opc == 4'hA) || (w_opc == 4'hB);
    assign w_rd_last = (r_cnt == c_RD_LAST);
    assign w_wr_last = (r_cnt == c_WR_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs (all outputs decode from registered state so
    // strobes and tx_req drop in the first cycle after reset is sampled)
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_tx_data = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_rd) begin
                    w_next = S_RD;
                end else if (w_accept && w_is_wr) begin
                    w_next = S_WR;
                end
            end
            S_RD: begin
                if (w_rd_last) begin
                    w_next = S_TX;
                end
            end
            S_TX: begin
                case (r_idx)
                    2'd0:    w_tx_data = {4'h3, r_rdat[3:0]};
                    2'd1:    w_tx_data = {4'h4, r_rdat[7:4]};
                    2'd2:    w_tx_data = {4'h5, r_rdat[11:8]};
                    default: w_tx_data = {4'h6, r_rdat[15:12]};
                endcase
                if (tx_ack && (r_idx == 2'd3)) begin
                    w_next = S_IDLE;
                end
            end
            S_WR: begin
                if (w_wr_last) begin
`ifdef SPY_WRITE_ECHO_EN
                    w_next = S_ECHO;
`else
                    w_next = S_IDLE;
`endif
                end
            end
`ifdef SPY_WRITE_ECHO_EN
            S_ECHO: begin
                w_tx_data = r_cmd;
                if (tx_ack) begin
                    w_next = S_IDLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

`ifdef SPY_WRITE_ECHO_EN
    assign tx_req = (r_state == S_TX) || (r_state == S_ECHO);
`else
    assign tx_req = (r_state == S_TX);
`endif
    assign tx_data    = w_tx_data;
    assign dbread     = (r_state == S_RD);
    assign dbwrite    = (r_state == S_WR);
    assign eadr       = r_eadr;
    assign spy_out    = r_data;
    assign rx_overrun = r_ovr;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= 16'h0000;
            r_rdat <= 16'h0000;
            r_eadr <= 5'd0;
            r_cnt  <= '0;
            r_idx  <= 2'd0;
            r_ovr  <= 1'b0;
`ifdef SPY_WRITE_ECHO_EN
            r_cmd  <= 8'h00;
`endif
        end else begin
            // Strobe-width counter restarts whenever a strobe phase ends.
            if ((r_state == S_RD && !w_rd_last) || (r_state == S_WR && !w_wr_last)) begin
                r_cnt <= r_cnt + c_CW'(1);
            end else begin
                r_cnt <= '0;
            end

            if (w_accept) begin
                case (w_opc)
                    4'h3:    r_data[3:0]   <= w_arg;
                    4'h4:    r_data[7:4]   <= w_arg;
                    4'h5:    r_data[11:8]  <= w_arg;
                    4'h6:    r_data[15:12] <= w_arg;
                    default: ;
                endcase
                if (w_is_rd || w_is_wr) begin
                    r_eadr <= {w_opc[0], w_arg};
`ifdef SPY_WRITE_ECHO_EN
                    r_cmd  <= rx_data;
`endif
                end
            end

            if ((r_state == S_RD) && w_rd_last) begin
                r_rdat <= spy_in;
            end

            // Index wraps 3 -> 0 on the last accept, ready for the next read.
            if ((r_state == S_TX) && tx_ack) begin
                r_idx <= r_idx + 2'd1;
            end

            if (rx_valid && (r_state != S_IDLE)) begin
                r_ovr <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spy_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spy_cmd_decoder
//  Description : Directed self-checking bench for spy_cmd_decoder
//                (READ_CYCLES = WRITE_CYCLES = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spy_cmd_decoder;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        tx_ack;
    logic [15:0] spy_in;
    logic [15:0] spy_out;
    logic [4:0]  eadr;
    logic        dbread;
    logic        dbwrite;
    logic        rx_overrun;

    int n_chk  = 0;
    int n_fail = 0;

    spy_cmd_decoder #(
        .READ_CYCLES  (2),
        .WRITE_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_ack     (tx_ack),
        .spy_in     (spy_in),
        .spy_out    (spy_out),
        .eadr       (eadr),
        .dbread     (dbread),
        .dbwrite    (dbwrite),
        .rx_overrun (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (!tx_req && k < 20) begin
            step();
            k++;
        end
        chk({tag, "_req"}, {31'd0, tx_req}, 32'd1);
    endtask

    task automatic recv(input string tag, input logic [7:0] exp);
        wait_req(tag);
        chk(tag, {24'd0, tx_data}, {24'd0, exp});
        tx_ack = 1'b1;
        step();
        tx_ack = 1'b0;
    endtask

    // Check a 2-cycle write strobe starting in the current cycle.
    task automatic chk_write(input string tag, input logic [4:0] ea, input logic [15:0] d);
        chk({tag, "_c1_wr"}, {31'd0, dbwrite}, 32'd1);
        chk({tag, "_c1_ea"}, {27'd0, eadr}, {27'd0, ea});
        chk({tag, "_c1_do"}, {16'd0, spy_out}, {16'd0, d});
        chk({tag, "_c1_rd"}, {31'd0, dbread}, 32'd0);
        step();
        chk({tag, "_c2_wr"}, {31'd0, dbwrite}, 32'd1);
        chk({tag, "_c2_ea"}, {27'd0, eadr}, {27'd0, ea});
        chk({tag, "_c2_do"}, {16'd0, spy_out}, {16'd0, d});
        step();
        chk({tag, "_c3_wr"}, {31'd0, dbwrite}, 32'd0);
    endtask

    // Check a 2-cycle read strobe starting in the current cycle; spy_in is
    // only valid on the second (last) cycle.
    task automatic chk_read(input string tag, input logic [4:0] ea, input logic [15:0] d);
        spy_in = ~d;
        chk({tag, "_c1_rd"}, {31'd0, dbread}, 32'd1);
        chk({tag, "_c1_ea"}, {27'd0, eadr}, {27'd0, ea});
        chk({tag, "_c1_wr"}, {31'd0, dbwrite}, 32'd0);
        chk({tag, "_c1_tx"}, {31'd0, tx_req}, 32'd0);
        step();
        spy_in = d;
        chk({tag, "_c2_rd"}, {31'd0, dbread}, 32'd1);
        chk({tag, "_c2_tx"}, {31'd0, tx_req}, 32'd0);
        step();
        spy_in = 16'h0000;
        chk({tag, "_c3_rd"}, {31'd0, dbread}, 32'd0);
    endtask

    initial begin
        int bad;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ack   = 1'b0;
        spy_in   = 16'h0000;

        // 1. Reset and idle quiet period
        step(); step(); step();
        reset = 1'b0;
        chk("rst_tx_req",  {31'd0, tx_req}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_spy_out", {16'd0, spy_out}, 32'd0);
        chk("rst_eadr",    {27'd0, eadr}, 32'd0);
        chk("rst_dbread",  {31'd0, dbread}, 32'd0);
        chk("rst_dbwrite", {31'd0, dbwrite}, 32'd0);
        chk("rst_ovr",     {31'd0, rx_overrun}, 32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx_req || dbread || dbwrite || rx_overrun) bad++;
        end
        chk("idle_quiet", bad, 0);

        // 2. Nibble loads then two writes reusing the data register
        send(8'h34); send(8'h43); send(8'h52); send(8'h61);
        chk("load_spy_out", {16'd0, spy_out}, 32'h1234);
        chk("load_no_wr",   {31'd0, dbwrite}, 32'd0);
        send(8'hA8);
        chk_write("wr08", 5'h08, 16'h1234);
`ifdef SPY_WRITE_ECHO_EN
        recv("echoA8", 8'hA8);
`endif
        step();
        send(8'hA9);
        chk_write("wr09", 5'h09, 16'h1234);
`ifdef SPY_WRITE_ECHO_EN
        recv("echoA9", 8'hA9);
`endif
        chk("wr_no_ovr", {31'd0, rx_overrun}, 32'd0);

        // Ignored opcodes: no strobe, no data change, no flag
        send(8'h00); send(8'hF5); send(8'h70); send(8'h2C);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (dbread || dbwrite || tx_req) bad++;
            step();
        end
        chk("ign_quiet", bad, 0);
        chk("ign_data",  {16'd0, spy_out}, 32'h1234);
        chk("ign_ovr",   {31'd0, rx_overrun}, 32'd0);

        // 3. Read register 0x10 and return BEEF
        send(8'h90);
        chk_read("rd10", 5'h10, 16'hBEEF);
        recv("beef0", 8'h3F);
        recv("beef1", 8'h4E);
        recv("beef2", 8'h5E);
        recv("beef3", 8'h6B);
        chk("beef_done", {31'd0, tx_req}, 32'd0);
        step();
        chk("beef_idle", {31'd0, tx_req}, 32'd0);

        // 4. Stalled transmitter with an overrun byte
        send(8'h81);
        chk_read("rd01", 5'h01, 16'hCAF1);
        wait_req("stall");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin
                rx_data  = 8'h35;
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            if (!tx_req || tx_data !== 8'h31) bad++;
            step();
        end
        rx_valid = 1'b0;
        chk("stall_hold", bad, 0);
        chk("stall_ovr",  {31'd0, rx_overrun}, 32'd1);
        chk("stall_data", {16'd0, spy_out}, 32'h1234);
        recv("caf0", 8'h31);
        recv("caf1", 8'h4F);
        recv("caf2", 8'h5A);
        recv("caf3", 8'h6C);
        chk("caf_done", {31'd0, tx_req}, 32'd0);
        chk("ovr_sticky", {31'd0, rx_overrun}, 32'd1);

        // 5. Reset with the second tx byte pending
        send(8'h80);
        chk_read("rd00a", 5'h00, 16'h5678);
        recv("r5_0", 8'h38);
        wait_req("r5_1");
        chk("r5_1_data", {24'd0, tx_data}, 32'h47);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_req",  {31'd0, tx_req}, 32'd0);
        chk("mid_rst_data", {16'd0, spy_out}, 32'd0);
        chk("mid_rst_ovr",  {31'd0, rx_overrun}, 32'd0);
        chk("mid_rst_eadr", {27'd0, eadr}, 32'd0);
        send(8'h80);
        chk_read("rd00b", 5'h00, 16'h9ABC);
        recv("abc0", 8'h3C);
        recv("abc1", 8'h4B);
        recv("abc2", 8'h5A);
        recv("abc3", 8'h69);
        chk("abc_done", {31'd0, tx_req}, 32'd0);

        // 6. Write 0xA3: echo only when the feature is built
        send(8'hA3);
        chk_write("wr03", 5'h03, 16'h0000);
`ifdef SPY_WRITE_ECHO_EN
        recv("echoA3", 8'hA3);
        chk("echo_done", {31'd0, tx_req}, 32'd0);
`else
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_req) bad++;
            step();
        end
        chk("no_echo", bad, 0);
`endif

        // Byte arriving on the cycle the write returns to IDLE is dropped
        send(8'hB1);
        chk("wr11_c1", {31'd0, dbwrite}, 32'd1);
        chk("wr11_ea", {27'd0, eadr}, 32'h11);
        step();
        rx_data  = 8'h3F;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        chk("edge_drop_data", {16'd0, spy_out}, 32'd0);
        chk("edge_drop_ovr",  {31'd0, rx_overrun}, 32'd1);
`ifdef SPY_WRITE_ECHO_EN
        recv("echoB1", 8'hB1);
`endif
        step();
        chk("final_idle", {31'd0, tx_req | dbread | dbwrite}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
